// File: rtl/writeback_sequencer_pkg.sv
// Shared types and constants for the writeback sequencer.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package writeback_sequencer_pkg;

  typedef enum logic {
    WB_IDLE   = 1'b0,
    WB_SECOND = 1'b1
  } wb_state_t;

  // General purpose register numbers
  localparam logic [2:0] REG_EAX = 3'd0;
  localparam logic [2:0] REG_ECX = 3'd1;
  localparam logic [2:0] REG_EDX = 3'd2;
  localparam logic [2:0] REG_EBX = 3'd3;
  localparam logic [2:0] REG_ESP = 3'd4;
  localparam logic [2:0] REG_EBP = 3'd5;
  localparam logic [2:0] REG_ESI = 3'd6;
  localparam logic [2:0] REG_EDI = 3'd7;

  // Segment register numbers
  localparam logic [2:0] SEG_ES = 3'd0;
  localparam logic [2:0] SEG_CS = 3'd1;
  localparam logic [2:0] SEG_SS = 3'd2;
  localparam logic [2:0] SEG_DS = 3'd3;
  localparam logic [2:0] SEG_FS = 3'd4;
  localparam logic [2:0] SEG_GS = 3'd5;

  // Operand size codes carried alongside GPR writes
  localparam logic [2:0] SIZE_BYTE  = 3'd0;
  localparam logic [2:0] SIZE_WORD  = 3'd1;
  localparam logic [2:0] SIZE_DWORD = 3'd2;

  // One bit per GPR, used to build pending set/clear masks
  function automatic logic [7:0] reg_onehot(input logic [2:0] num);
    logic [7:0] m;
    m = 8'd0;
    m[num] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/writeback_sequencer.sv
// Serialises execute-stage writebacks onto single GPR/seg/MMX write ports.
// Latency: 1 cycle for reg0/seg/mmx; reg1 follows one cycle later.
// Backpressure: e_ready drops for the reg1 cycle, during flush and during reset.
module writeback_sequencer
  import writeback_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        e_valid,
  output logic        e_ready,
  input  logic        e_reg0_en,
  input  logic [2:0]  e_reg0_number,
  input  logic [2:0]  e_reg0_size,
  input  logic [31:0] e_reg0_data,
  input  logic        e_reg1_en,
  input  logic [2:0]  e_reg1_number,
  input  logic [2:0]  e_reg1_size,
  input  logic [31:0] e_reg1_data,
  input  logic        e_seg_en,
  input  logic [2:0]  e_seg_number,
  input  logic [15:0] e_seg_data,
  input  logic        e_mmx_en,
  input  logic [2:0]  e_mmx_number,
  input  logic [63:0] e_mmx_data,
  output logic        wb_reg_en,
  output logic [2:0]  wb_reg_number,
  output logic [2:0]  wb_reg_size,
  output logic [31:0] wb_reg_data,
  output logic        wb_seg_en,
  output logic [2:0]  wb_seg_number,
  output logic [15:0] wb_seg_data,
  output logic        wb_mmx_en,
  output logic [2:0]  wb_mmx_number,
  output logic [63:0] wb_mmx_data,
  output logic [7:0]  wb_reg_pending,
  output logic [31:0] wb_retire_count
);

  wb_state_t   state, state_nxt;
  logic        handshake;

  // reg1 write held over for the second output cycle
  logic [2:0]  r1_number, r1_size;
  logic [31:0] r1_data;

  // set while the port is showing an instruction's final write cycle
  logic        out_last;

  logic        nx_reg_en;
  logic [2:0]  nx_reg_number, nx_reg_size;
  logic [31:0] nx_reg_data;
  logic        nx_seg_en;
  logic [2:0]  nx_seg_number;
  logic [15:0] nx_seg_data;
  logic        nx_mmx_en;
  logic [2:0]  nx_mmx_number;
  logic [63:0] nx_mmx_data;
  logic        nx_last;
  logic [7:0]  pend_set, pend_clr;

  // Next state, handshake and next port contents; disabled ports stay all-zero
  always_comb begin
    state_nxt     = state;
    e_ready       = 1'b0;
    handshake     = 1'b0;
    nx_reg_en     = 1'b0;
    nx_reg_number = 3'd0;
    nx_reg_size   = 3'd0;
    nx_reg_data   = 32'd0;
    nx_seg_en     = 1'b0;
    nx_seg_number = 3'd0;
    nx_seg_data   = 16'd0;
    nx_mmx_en     = 1'b0;
    nx_mmx_number = 3'd0;
    nx_mmx_data   = 64'd0;
    nx_last       = 1'b0;
    case (state)
      WB_IDLE: begin
        e_ready   = !flush && !reset;
        handshake = e_valid && !flush && !reset;
        if (handshake) begin
          nx_last = !e_reg1_en;
          if (e_reg1_en) state_nxt = WB_SECOND;
          if (e_reg0_en) begin
            nx_reg_en     = 1'b1;
            nx_reg_number = e_reg0_number;
            nx_reg_size   = e_reg0_size;
            nx_reg_data   = e_reg0_data;
          end
          if (e_seg_en) begin
            nx_seg_en     = 1'b1;
            nx_seg_number = e_seg_number;
            nx_seg_data   = e_seg_data;
          end
          if (e_mmx_en) begin
            nx_mmx_en     = 1'b1;
            nx_mmx_number = e_mmx_number;
            nx_mmx_data   = e_mmx_data;
          end
        end
      end
      WB_SECOND: begin
        // reg1 issues regardless of flush: it belongs to an accepted instruction
        nx_reg_en     = 1'b1;
        nx_reg_number = r1_number;
        nx_reg_size   = r1_size;
        nx_reg_data   = r1_data;
        nx_last       = 1'b1;
        state_nxt     = WB_IDLE;
      end
      default: state_nxt = WB_IDLE;
    endcase
  end

  // Pending masks: a bit clears after its write is on the port, except when the
  // held reg1 targets the same register and is still to come
  always_comb begin
    pend_set = 8'd0;
    pend_clr = 8'd0;
    if (handshake) begin
      if (e_reg0_en) pend_set = pend_set | reg_onehot(e_reg0_number);
      if (e_reg1_en) pend_set = pend_set | reg_onehot(e_reg1_number);
    end
    if (wb_reg_en) pend_clr = reg_onehot(wb_reg_number);
    if (state == WB_SECOND) pend_clr = pend_clr & ~reg_onehot(r1_number);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= WB_IDLE;
    else       state <= state_nxt;
  end

  // Registered write ports, pending bits, retire counter and reg1 holding
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_reg_en       <= 1'b0;
      wb_reg_number   <= 3'd0;
      wb_reg_size     <= 3'd0;
      wb_reg_data     <= 32'd0;
      wb_seg_en       <= 1'b0;
      wb_seg_number   <= 3'd0;
      wb_seg_data     <= 16'd0;
      wb_mmx_en       <= 1'b0;
      wb_mmx_number   <= 3'd0;
      wb_mmx_data     <= 64'd0;
      wb_reg_pending  <= 8'd0;
      wb_retire_count <= 32'd0;
      out_last        <= 1'b0;
      r1_number       <= 3'd0;
      r1_size         <= 3'd0;
      r1_data         <= 32'd0;
    end else begin
      wb_reg_en       <= nx_reg_en;
      wb_reg_number   <= nx_reg_number;
      wb_reg_size     <= nx_reg_size;
      wb_reg_data     <= nx_reg_data;
      wb_seg_en       <= nx_seg_en;
      wb_seg_number   <= nx_seg_number;
      wb_seg_data     <= nx_seg_data;
      wb_mmx_en       <= nx_mmx_en;
      wb_mmx_number   <= nx_mmx_number;
      wb_mmx_data     <= nx_mmx_data;
      wb_reg_pending  <= (wb_reg_pending & ~pend_clr) | pend_set;
      wb_retire_count <= wb_retire_count + {31'd0, out_last};
      out_last        <= nx_last;
      if (handshake) begin
        r1_number <= e_reg1_number;
        r1_size   <= e_reg1_size;
        r1_data   <= e_reg1_data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_sequencer.sv
module tb_writeback_sequencer;
  import writeback_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, e_valid, e_ready;
  logic        e_reg0_en, e_reg1_en, e_seg_en, e_mmx_en;
  logic [2:0]  e_reg0_number, e_reg0_size, e_reg1_number, e_reg1_size;
  logic [2:0]  e_seg_number, e_mmx_number;
  logic [31:0] e_reg0_data, e_reg1_data;
  logic [15:0] e_seg_data;
  logic [63:0] e_mmx_data;
  logic        wb_reg_en, wb_seg_en, wb_mmx_en;
  logic [2:0]  wb_reg_number, wb_reg_size, wb_seg_number, wb_mmx_number;
  logic [31:0] wb_reg_data, wb_retire_count;
  logic [15:0] wb_seg_data;
  logic [63:0] wb_mmx_data;
  logic [7:0]  wb_reg_pending;

  typedef struct packed {
    logic        r0_en;  logic [2:0] r0_num; logic [2:0] r0_size; logic [31:0] r0_data;
    logic        r1_en;  logic [2:0] r1_num; logic [2:0] r1_size; logic [31:0] r1_data;
    logic        s_en;   logic [2:0] s_num;  logic [15:0] s_data;
    logic        m_en;   logic [2:0] m_num;  logic [63:0] m_data;
  } instr_t;

  typedef struct {
    int           cyc;
    logic [126:0] vec;
    bit           last;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          mon_on = 1'b0;
  logic [31:0] exp_retire = 32'd0;

  writeback_sequencer dut (
    .clk(clk), .reset(reset), .flush(flush), .e_valid(e_valid), .e_ready(e_ready),
    .e_reg0_en(e_reg0_en), .e_reg0_number(e_reg0_number), .e_reg0_size(e_reg0_size),
    .e_reg0_data(e_reg0_data),
    .e_reg1_en(e_reg1_en), .e_reg1_number(e_reg1_number), .e_reg1_size(e_reg1_size),
    .e_reg1_data(e_reg1_data),
    .e_seg_en(e_seg_en), .e_seg_number(e_seg_number), .e_seg_data(e_seg_data),
    .e_mmx_en(e_mmx_en), .e_mmx_number(e_mmx_number), .e_mmx_data(e_mmx_data),
    .wb_reg_en(wb_reg_en), .wb_reg_number(wb_reg_number), .wb_reg_size(wb_reg_size),
    .wb_reg_data(wb_reg_data),
    .wb_seg_en(wb_seg_en), .wb_seg_number(wb_seg_number), .wb_seg_data(wb_seg_data),
    .wb_mmx_en(wb_mmx_en), .wb_mmx_number(wb_mmx_number), .wb_mmx_data(wb_mmx_data),
    .wb_reg_pending(wb_reg_pending), .wb_retire_count(wb_retire_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [126:0] port_vec(
      input logic r_en, input logic [2:0] r_num, input logic [2:0] r_size, input logic [31:0] r_data,
      input logic s_en, input logic [2:0] s_num, input logic [15:0] s_data,
      input logic m_en, input logic [2:0] m_num, input logic [63:0] m_data);
    logic [38:0] r;
    logic [19:0] s;
    logic [67:0] m;
    r = r_en ? {1'b1, r_num, r_size, r_data} : 39'd0;
    s = s_en ? {1'b1, s_num, s_data} : 20'd0;
    m = m_en ? {1'b1, m_num, m_data} : 68'd0;
    return {r, s, m};
  endfunction

  function automatic logic [126:0] dut_vec();
    return {wb_reg_en, wb_reg_number, wb_reg_size, wb_reg_data,
            wb_seg_en, wb_seg_number, wb_seg_data,
            wb_mmx_en, wb_mmx_number, wb_mmx_data};
  endfunction

  // Scoreboard monitor: every cycle the port must match the scheduled record or be idle
  always @(negedge clk) begin
    if (mon_on) begin
      total++;
      if (wb_retire_count !== exp_retire) begin
        bad++;
        $display("FAIL retire_count cyc=%0d got=%h want=%h", cyc, wb_retire_count, exp_retire);
      end
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL missed_write cyc=%0d got=none want=record for cyc %0d", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      total++;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_t r;
        r = sb.pop_front();
        if (dut_vec() !== r.vec) begin
          bad++;
          $display("FAIL port cyc=%0d got=%h want=%h", cyc, dut_vec(), r.vec);
        end
        if (r.last) exp_retire = exp_retire + 32'd1;
      end else if (dut_vec() !== 127'd0) begin
        bad++;
        $display("FAIL idle_port cyc=%0d got=%h want=0", cyc, dut_vec());
      end
    end
  end

  task automatic drive(input instr_t in);
    e_reg0_en = in.r0_en; e_reg0_number = in.r0_num; e_reg0_size = in.r0_size; e_reg0_data = in.r0_data;
    e_reg1_en = in.r1_en; e_reg1_number = in.r1_num; e_reg1_size = in.r1_size; e_reg1_data = in.r1_data;
    e_seg_en = in.s_en; e_seg_number = in.s_num; e_seg_data = in.s_data;
    e_mmx_en = in.m_en; e_mmx_number = in.m_num; e_mmx_data = in.m_data;
  endtask

  task automatic push_expected(input instr_t in);
    exp_t r;
    r.cyc  = cyc + 1;
    r.vec  = port_vec(in.r0_en, in.r0_num, in.r0_size, in.r0_data,
                      in.s_en, in.s_num, in.s_data, in.m_en, in.m_num, in.m_data);
    r.last = !in.r1_en;
    sb.push_back(r);
    if (in.r1_en) begin
      r.cyc  = cyc + 2;
      r.vec  = port_vec(1'b1, in.r1_num, in.r1_size, in.r1_data,
                        1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 64'd0);
      r.last = 1'b1;
      sb.push_back(r);
    end
  endtask

  // Called just after a falling edge; returns at the next falling edge
  task automatic offer(input instr_t in, input bit fl, output bit acc);
    drive(in);
    e_valid = 1'b1;
    flush   = fl;
    #1;
    acc = e_ready;
    if (acc) push_expected(in);
    @(negedge clk);
    e_valid = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic do_reset();
    mon_on  = 1'b0;
    reset   = 1'b1;
    e_valid = 1'b0;
    flush   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    exp_retire = 32'd0;
    mon_on = 1'b1;
  endtask

  function automatic instr_t mk(input logic r0e, input logic [2:0] r0n, input logic [31:0] r0d,
                                input logic r1e, input logic [2:0] r1n, input logic [31:0] r1d);
    instr_t t;
    t = '0;
    t.r0_en = r0e; t.r0_num = r0n; t.r0_size = SIZE_DWORD; t.r0_data = r0d;
    t.r1_en = r1e; t.r1_num = r1n; t.r1_size = SIZE_DWORD; t.r1_data = r1d;
    return t;
  endfunction

  task automatic test_reset();
    instr_t t;
    t = mk(1'b1, REG_EAX, 32'hDEAD_BEEF, 1'b1, REG_ESP, 32'h1);
    drive(t);
    reset = 1'b1; e_valid = 1'b1; flush = 1'b0;
    @(negedge clk); #1;
    total++;
    if (e_ready !== 1'b0) begin bad++; $display("FAIL reset_e_ready got=%b want=0", e_ready); end
    @(negedge clk);
    total++;
    if ({dut_vec(), wb_reg_pending, wb_retire_count} !== 167'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h pend=%h cnt=%h want=0", dut_vec(), wb_reg_pending, wb_retire_count);
    end
    e_valid = 1'b0;
    reset   = 1'b0;
    sb.delete();
    exp_retire = 32'd0;
    mon_on = 1'b1;
  endtask

  task automatic test_single();
    bit acc;
    offer(mk(1'b1, REG_EAX, 32'h1234_5678, 1'b0, 3'd0, 32'd0), 1'b0, acc);
    total++;
    if (acc !== 1'b1 || wb_reg_pending[0] !== 1'b1) begin
      bad++; $display("FAIL single_accept_pending got=%b/%b want=1/1", acc, wb_reg_pending[0]);
    end
    @(negedge clk);
    total++;
    if (wb_retire_count !== 32'd1 || wb_reg_pending[0] !== 1'b0) begin
      bad++; $display("FAIL single_retire got=%h/%b want=1/0", wb_retire_count, wb_reg_pending[0]);
    end
  endtask

  task automatic test_push();
    bit acc;
    instr_t t;
    t = mk(1'b0, 3'd0, 32'd0, 1'b1, REG_ESP, 32'h0000_0FFC);
    t.s_en = 1'b1; t.s_num = SEG_DS; t.s_data = 16'h0010;
    offer(t, 1'b0, acc);
    #1;
    total++;
    if (e_ready !== 1'b0) begin bad++; $display("FAIL push_e_ready got=%b want=0", e_ready); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit acc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      offer(mk(1'b1, 3'(i + 4), 32'hA000_0000 + 32'(i), 1'b0, 3'd0, 32'd0), 1'b0, acc);
      total++;
      if (acc !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, acc); end
    end
    repeat (2) @(negedge clk);
    total++;
    if (wb_retire_count !== 32'd4) begin
      bad++; $display("FAIL b2b_count got=%0d want=4", wb_retire_count);
    end
  endtask

  task automatic test_flush();
    bit acc;
    offer(mk(1'b1, REG_EDI, 32'hBAD0_0001, 1'b0, 3'd0, 32'd0), 1'b1, acc);
    total++;
    if (acc !== 1'b0) begin bad++; $display("FAIL flush_idle_accept got=%b want=0", acc); end
    offer(mk(1'b1, REG_EDX, 32'h0000_00D0, 1'b1, REG_ECX, 32'h0000_00C1), 1'b0, acc);
    offer(mk(1'b1, REG_ESI, 32'hBAD0_0002, 1'b0, 3'd0, 32'd0), 1'b1, acc);
    total++;
    if (acc !== 1'b0) begin bad++; $display("FAIL flush_second_accept got=%b want=0", acc); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_same_reg();
    bit acc;
    offer(mk(1'b1, REG_EBX, 32'h1, 1'b1, REG_EBX, 32'h2), 1'b0, acc);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (wb_reg_pending[3] !== (i < 2)) begin
        bad++; $display("FAIL same_reg_pending[%0d] got=%b want=%b", i, wb_reg_pending[3], i < 2);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_all_disabled();
    bit acc;
    instr_t t;
    t = mk(1'b0, REG_EAX, 32'hFFFF_FFFF, 1'b0, REG_EAX, 32'hFFFF_FFFF);
    t.s_num = SEG_GS; t.m_num = 3'd7; t.m_data = 64'hFFFF_FFFF_FFFF_FFFF;
    offer(t, 1'b0, acc);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap_and_reset_second();
    bit acc;
    #1;
    mon_on = 1'b0;
    force dut.wb_retire_count = 32'hFFFF_FFFF;
    #1;
    release dut.wb_retire_count;
    exp_retire = 32'hFFFF_FFFF;
    mon_on = 1'b1;
    @(negedge clk);
    offer(mk(1'b1, REG_EBP, 32'h0000_BEEF, 1'b0, 3'd0, 32'd0), 1'b0, acc);
    @(negedge clk);
    total++;
    if (wb_retire_count !== 32'd0) begin
      bad++; $display("FAIL wrap_count got=%h want=0", wb_retire_count);
    end
    offer(mk(1'b1, REG_ECX, 32'h0000_0C0C, 1'b1, REG_ESP, 32'h0000_1234), 1'b0, acc);
    #1;
    mon_on = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    total++;
    if ({dut_vec(), wb_reg_pending, wb_retire_count, e_ready} !== 168'd0) begin
      bad++;
      $display("FAIL reset_second got=%h pend=%h cnt=%h rdy=%b want=0",
               dut_vec(), wb_reg_pending, wb_retire_count, e_ready);
    end
    reset = 1'b0;
    sb.delete();
    exp_retire = 32'd0;
    mon_on = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; e_valid = 1'b0;
    drive('0);
    @(negedge clk);
    test_reset();
    test_single();
    test_push();
    test_flush();
    test_same_reg();
    test_all_disabled();
    test_back_to_back();
    test_wrap_and_reset_second();
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL leftover_records got=%0d want=0", sb.size()); end
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
